// File: rtl/morse_dec_pkg.sv
// Shared constants, FSM state type and lookup tables for the Morse decoder.
package morse_dec_pkg;

  localparam int unsigned DurW = 12;

  localparam logic [5:0] CODE_SPACE = 6'd36;
  localparam logic [5:0] CODE_ERR   = 6'd63;

  // Elements the buffer can hold before the character is flagged as an error
  localparam logic [2:0] MAX_ELEMS  = 3'd6;

  typedef enum logic [1:0] {StIdle, StMark, StSpace} state_e;

  // Unit length in ms: floor(1200 / (5 + 2*sel))
  function automatic logic [7:0] unit_ms(input logic [3:0] sel);
    logic [7:0] u;
    case (sel)
      4'd0:    u = 8'd240;
      4'd1:    u = 8'd171;
      4'd2:    u = 8'd133;
      4'd3:    u = 8'd109;
      4'd4:    u = 8'd92;
      4'd5:    u = 8'd80;
      4'd6:    u = 8'd70;
      4'd7:    u = 8'd63;
      4'd8:    u = 8'd57;
      4'd9:    u = 8'd52;
      4'd10:   u = 8'd48;
      4'd11:   u = 8'd44;
      4'd12:   u = 8'd41;
      4'd13:   u = 8'd38;
      4'd14:   u = 8'd36;
      default: u = 8'd34;
    endcase
    return u;
  endfunction

  // Active-high segments {G,F,E,D,C,B,A}; letters use the usual mixed-case glyphs
  function automatic logic [6:0] code_to_seg(input logic [5:0] code);
    logic [6:0] s;
    case (code)
      6'd0:    s = 7'h77;  // A
      6'd1:    s = 7'h7C;  // b
      6'd2:    s = 7'h39;  // C
      6'd3:    s = 7'h5E;  // d
      6'd4:    s = 7'h79;  // E
      6'd5:    s = 7'h71;  // F
      6'd6:    s = 7'h3D;  // G
      6'd7:    s = 7'h76;  // H
      6'd8:    s = 7'h30;  // I
      6'd9:    s = 7'h1E;  // J
      6'd10:   s = 7'h75;  // K
      6'd11:   s = 7'h38;  // L
      6'd12:   s = 7'h37;  // M
      6'd13:   s = 7'h54;  // n
      6'd14:   s = 7'h5C;  // o
      6'd15:   s = 7'h73;  // P
      6'd16:   s = 7'h67;  // q
      6'd17:   s = 7'h50;  // r
      6'd18:   s = 7'h6D;  // S
      6'd19:   s = 7'h78;  // t
      6'd20:   s = 7'h3E;  // U
      6'd21:   s = 7'h1C;  // v
      6'd22:   s = 7'h2A;  // W
      6'd23:   s = 7'h49;  // X
      6'd24:   s = 7'h6E;  // y
      6'd25:   s = 7'h5B;  // Z
      6'd26:   s = 7'h3F;  // 0
      6'd27:   s = 7'h06;  // 1
      6'd28:   s = 7'h5B;  // 2
      6'd29:   s = 7'h4F;  // 3
      6'd30:   s = 7'h66;  // 4
      6'd31:   s = 7'h6D;  // 5
      6'd32:   s = 7'h7D;  // 6
      6'd33:   s = 7'h07;  // 7
      6'd34:   s = 7'h7F;  // 8
      6'd35:   s = 7'h6F;  // 9
      6'd36:   s = 7'h00;  // space: blank
      default: s = 7'h40;  // error: centre bar
    endcase
    return s;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Element pattern to character code. The first element sits at bit count-1,
// the last at bit 0; dit = 0, dah = 1. Unassigned patterns give CODE_ERR.
module morse_lut
  import morse_dec_pkg::*;
(
  input  logic [5:0] pattern_i,
  input  logic [2:0] count_i,
  output logic [5:0] code_o
);

  // Six-element patterns are never valid, so the top bit carries no information
  logic unused_pattern_msb;
  assign unused_pattern_msb = pattern_i[5];

  // Decode per element count
  always_comb begin
    code_o = CODE_ERR;
    case (count_i)
      3'd1: code_o = pattern_i[0] ? 6'd19 : 6'd4;  // T / E
      3'd2: begin
        case (pattern_i[1:0])
          2'b01:   code_o = 6'd0;   // A
          2'b00:   code_o = 6'd8;   // I
          2'b11:   code_o = 6'd12;  // M
          default: code_o = 6'd13;  // N
        endcase
      end
      3'd3: begin
        case (pattern_i[2:0])
          3'b100:  code_o = 6'd3;   // D
          3'b110:  code_o = 6'd6;   // G
          3'b101:  code_o = 6'd10;  // K
          3'b111:  code_o = 6'd14;  // O
          3'b010:  code_o = 6'd17;  // R
          3'b000:  code_o = 6'd18;  // S
          3'b001:  code_o = 6'd20;  // U
          default: code_o = 6'd22;  // W
        endcase
      end
      3'd4: begin
        case (pattern_i[3:0])
          4'b1000: code_o = 6'd1;   // B
          4'b1010: code_o = 6'd2;   // C
          4'b0010: code_o = 6'd5;   // F
          4'b0000: code_o = 6'd7;   // H
          4'b0111: code_o = 6'd9;   // J
          4'b0100: code_o = 6'd11;  // L
          4'b0110: code_o = 6'd15;  // P
          4'b1101: code_o = 6'd16;  // Q
          4'b0001: code_o = 6'd21;  // V
          4'b1001: code_o = 6'd23;  // X
          4'b1011: code_o = 6'd24;  // Y
          4'b1100: code_o = 6'd25;  // Z
          default: code_o = CODE_ERR;
        endcase
      end
      3'd5: begin
        case (pattern_i[4:0])
          5'b11111: code_o = 6'd26;
          5'b01111: code_o = 6'd27;
          5'b00111: code_o = 6'd28;
          5'b00011: code_o = 6'd29;
          5'b00001: code_o = 6'd30;
          5'b00000: code_o = 6'd31;
          5'b10000: code_o = 6'd32;
          5'b11000: code_o = 6'd33;
          5'b11100: code_o = 6'd34;
          5'b11110: code_o = 6'd35;
          default:  code_o = CODE_ERR;
        endcase
      end
      default: code_o = CODE_ERR;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse keyer decoder: synchronizes the key, times marks and spaces in ms ticks,
// assembles dits/dahs and emits character codes with a seven-segment view.
// Optional macro MORSE_DEC_WORDGAP_EN enables the word-space (code 36) emission.
module morse_decoder
  import morse_dec_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       key_i,
  input  logic [3:0] wpm_sel_i,
  output logic [5:0] char_o,
  output logic       char_valid_o,
  output logic       error_o,
  output logic [7:0] seven_segment_o
);

  localparam int unsigned   PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [DurW-1:0] DurMax = '1;

  logic            key_meta_q, key_s_q, key_prev_q;
  logic            key_rise, key_fall;
  logic [PreW-1:0] pre_q;
  logic            tick;
  logic [7:0]      unit_q, unit_cur;
  logic [DurW-1:0] unit_ext, thr2, thr8;
  logic [DurW-1:0] dur_q, dur_d, dur_inc;
  logic            hit2, hit8;
  state_e          state_q, state_d;
  logic [5:0]      pat_q, pat_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic [5:0]      lut_code;
  logic            emit;
  logic [5:0]      emit_code;
  logic [5:0]      char_q;
  logic            valid_q, err_q;

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      key_meta_q <= key_i;
      key_s_q    <= key_meta_q;
      key_prev_q <= key_s_q;
    end
  end

  assign key_rise = key_s_q & ~key_prev_q;
  assign key_fall = ~key_s_q & key_prev_q;

  assign tick     = (pre_q == PreMax);
  // Speed is resampled on every tick and used on that same tick
  assign unit_cur = tick ? unit_ms(wpm_sel_i) : unit_q;

  // Free-running ms prescaler and sampled unit length
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_q  <= '0;
      unit_q <= unit_ms(4'd0);
    end else begin
      pre_q  <= tick ? '0 : pre_q + PreW'(1);
      unit_q <= unit_cur;
    end
  end

  assign unit_ext = DurW'(unit_cur);
  assign thr2     = unit_ext << 1;
  assign thr8     = unit_ext << 3;
  assign dur_inc  = (dur_q == DurMax) ? dur_q : dur_q + DurW'(1);
  assign dur_d    = (key_rise || key_fall) ? '0 : (tick ? dur_inc : dur_q);
  // A key edge zeroes dur_d, so an edge always wins over a threshold
  assign hit2     = tick && (dur_d >= thr2);
  assign hit8     = tick && (dur_d >= thr8);

`ifdef MORSE_DEC_WORDGAP_EN
  logic [DurW-1:0] thr5;
  logic            hit5;
  assign thr5 = (unit_ext << 2) + unit_ext;
  assign hit5 = tick && (dur_d >= thr5);
`endif

  // Saturating mark/space duration counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) dur_q <= '0;
    else         dur_q <= dur_d;
  end

  morse_lut u_lut (
    .pattern_i (pat_q),
    .count_i   (cnt_q),
    .code_o    (lut_code)
  );

  // FSM state and element buffer registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      pat_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state: element capture on key fall, character/word emission on gaps
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    flag_d    = flag_q;
    emit      = 1'b0;
    emit_code = CODE_SPACE;
    unique case (state_q)
      StIdle: begin
        if (key_rise) state_d = StMark;
      end
      StMark: begin
        if (key_fall) begin
          state_d = StSpace;
          if (cnt_q == MAX_ELEMS) begin
            flag_d = 1'b1;
          end else begin
            pat_d = {pat_q[4:0], (dur_q >= thr2)};
            cnt_d = cnt_q + 3'd1;
          end
        end else if (hit8) begin
          flag_d = 1'b1;
        end
      end
      StSpace: begin
        if (key_rise) begin
          state_d = StMark;
        end else if ((cnt_q != 3'd0) && hit2) begin
          emit      = 1'b1;
          emit_code = flag_q ? CODE_ERR : lut_code;
          pat_d     = '0;
          cnt_d     = '0;
          flag_d    = 1'b0;
`ifndef MORSE_DEC_WORDGAP_EN
          state_d   = StIdle;
`endif
        end
`ifdef MORSE_DEC_WORDGAP_EN
        else if ((cnt_q == 3'd0) && hit5) begin
          emit      = 1'b1;
          emit_code = CODE_SPACE;
          state_d   = StIdle;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs: code holds, valid/error pulse one cycle after the threshold tick
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      char_q  <= CODE_SPACE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= emit;
      err_q   <= emit && (emit_code == CODE_ERR);
      if (emit) char_q <= emit_code;
    end
  end

  assign char_o          = char_q;
  assign char_valid_o    = valid_q;
  assign error_o         = err_q;
  assign seven_segment_o = {key_s_q, code_to_seg(char_q)};

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized bench for morse_decoder with a string-level Morse reference model
// and a scoreboard of expected (code, cycle) emissions.
module tb_morse_decoder;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       key_i;
  logic [3:0] wpm_sel_i;
  logic [5:0] char_o;
  logic       char_valid_o;
  logic       error_o;
  logic [7:0] seven_segment_o;

  always #5 clk_i = ~clk_i;

  morse_decoder #(.TICK_DIV(1)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .key_i           (key_i),
    .wpm_sel_i       (wpm_sel_i),
    .char_o          (char_o),
    .char_valid_o    (char_valid_o),
    .error_o         (error_o),
    .seven_segment_o (seven_segment_o)
  );

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    unit     = 34;
  string elems    = "";
  bit    pend_err = 1'b0;

  string morse_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };
  int dig_seg [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int lookup(input string s);
    for (int i = 0; i < 36; i++) if (morse_tab[i] == s) return i;
    return 63;
  endfunction

  // Monitor: every output event is matched against the scoreboard head
  always @(negedge clk_i) begin
    exp_t e;
    if (char_valid_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_emit: got code %0d at cycle %0d, expected no emission",
                 char_o, cyc);
      end else begin
        e = sb.pop_front();
        check("code", 32'(char_o), e.code);
        check("emit_cycle", cyc, e.cyc);
        check("error_pulse", 32'(error_o), 32'(e.code == 63));
        if (e.code >= 26 && e.code <= 35)
          check("digit_seg", 32'(seven_segment_o[6:0]), dig_seg[e.code-26]);
        if (e.code == 36) check("space_seg", 32'(seven_segment_o[6:0]), 0);
      end
    end else if (error_o) begin
      n_checks++;
      $display("FAIL error_without_valid: got error_o=1 with char_valid_o=0, expected 0");
    end
  end

  task automatic drive(input logic lvl, input int n);
    key_i = lvl;
    repeat (n) @(posedge clk_i);
    #1;
    if (n >= 3) check(lvl ? "key_seg_mark" : "key_seg_space", 32'(seven_segment_o[7]), 32'(lvl));
  endtask

  task automatic do_mark(input int n);
    string el;
    el = (n > 2 * unit) ? "-" : ".";
    if (n > 8 * unit) pend_err = 1'b1;
    if (elems.len() >= 6) pend_err = 1'b1;
    else elems = {elems, el};
    drive(1'b1, n);
  endtask

  task automatic do_space(input int n);
    exp_t e;
    int   c;
    c = cyc;
    if (elems.len() > 0 && n > 2 * unit) begin
      e.code = pend_err ? 63 : lookup(elems);
      e.cyc  = c + 3 + 2 * unit;
      sb.push_back(e);
      elems    = "";
      pend_err = 1'b0;
`ifdef MORSE_DEC_WORDGAP_EN
      if (n > 5 * unit) begin
        e.code = 36;
        e.cyc  = c + 3 + 5 * unit;
        sb.push_back(e);
      end
`endif
    end
    drive(1'b0, n);
  endtask

  task automatic rand_char(input bit word);
    string pat;
    string el;
    int    ne;
    byte   ch;
    if ($urandom_range(0, 3) != 0) begin
      pat = morse_tab[$urandom_range(0, 35)];
    end else begin
      pat = "";
      ne  = $urandom_range(1, 7);
      for (int i = 0; i < ne; i++) begin
        el  = ($urandom_range(0, 1) != 0) ? "-" : ".";
        pat = {pat, el};
      end
    end
    for (int i = 0; i < pat.len(); i++) begin
      ch = pat.getc(i);
      if ($urandom_range(0, 19) == 0) do_mark(8 * unit + $urandom_range(20, 80));
      else if (ch == "-") do_mark($urandom_range(2 * unit + 6, 5 * unit));
      else do_mark($urandom_range(1, unit + unit / 2));
      if (i < pat.len() - 1) do_space($urandom_range(1, 2 * unit - 8));
    end
    if (word) do_space($urandom_range(5 * unit + 6, 5 * unit + 60));
    else do_space($urandom_range(2 * unit + 6, 5 * unit - 8));
  endtask

  initial begin
    int sel;
    rstn_i    = 1'b0;
    key_i     = 1'b0;
    wpm_sel_i = 4'd15;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_char", 32'(char_o), 36);
    check("rst_valid", 32'(char_valid_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_seg", 32'(seven_segment_o), 0);
    rstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // A with word gap
    do_mark(34); do_space(34); do_mark(102); do_space(200);
    // Digit 0
    for (int i = 0; i < 5; i++) begin
      do_mark(102);
      if (i < 4) do_space(34);
    end
    do_space(80);
    // Stuck key
    do_mark(300); do_space(80);
    // Seven dits overflow
    for (int i = 0; i < 7; i++) begin
      do_mark(34);
      if (i < 6) do_space(34);
    end
    do_space(80);
    // Key rise on the gap threshold tick: stays one character (A)
    do_mark(34); do_space(68); do_mark(102); do_space(80);
    // One tick past the threshold: E then E
    do_mark(34); do_space(69); do_mark(1); do_space(80);

    // Reset mid-character discards the pending elements
    do_mark(34); do_space(34); do_mark(34);
    key_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rstn_i   = 1'b0;
    elems    = "";
    pend_err = 1'b0;
    #2;
    check("midrst_char", 32'(char_o), 36);
    check("midrst_seg", 32'(seven_segment_o), 0);
    check("midrst_valid", 32'(char_valid_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    do_space(200);
    check("postrst_char", 32'(char_o), 36);
    check("postrst_seg", 32'(seven_segment_o), 0);

    for (int k = 0; k < 25; k++) rand_char($urandom_range(0, 2) == 0);
    rand_char(1'b1);

    // Other speeds; always leave the decoder idle before changing speed
    for (int k = 0; k < 4; k++) begin
      sel       = $urandom_range(10, 15);
      wpm_sel_i = 4'(sel);
      unit      = 1200 / (5 + 2 * sel);
      rand_char(1'b0);
      rand_char(1'b0);
      rand_char(1'b1);
    end

    repeat (20) @(posedge clk_i);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter: TICK_DIV, 10000, clk_i cycles per 1 ms timing tick (1 allowed for simulation).
REQ-002 Port: clk_i  in  1  sole clock, rising-edge.
REQ-003 Port: rstn_i  in  1  asynchronous, active-low reset.
REQ-004 Port: key_i  in  1  keyed Morse signal, active-high = mark; asynchronous to clk_i.
REQ-005 Port: wpm_sel_i  in  4  speed select; WPM = 5 + 2*wpm_sel_i.
REQ-006 Port: char_o  out  6  last decoded code: 0-25 = A-Z, 26-35 = 0-9, 36 = space, 63 = error.
REQ-007 Port: char_valid_o  out  1  one-cycle pulse when char_o is updated.
REQ-008 Port: error_o  out  1  one-cycle pulse coincident with char_valid_o when char_o = 63.
REQ-009 Port: seven_segment_o  out  8  [.GFEDCBA], active-high segments of char_o; bit 7 = live synchronized key.

Function
REQ-010 key_i shall pass a 2-flop synchronizer; all timing uses the synchronized key (key_s).
REQ-011 A prescaler shall emit a 1-cycle tick every TICK_DIV cycles; it runs freely from reset.
REQ-012 Unit length unit_ms = floor(1200/(5+2*wpm_sel_i)) from a 16-entry constant table; wpm_sel_i is sampled each tick (changes apply immediately).
REQ-013 A 12-bit duration counter shall clear on every key_s edge, increment on each tick, and saturate at 4095.
REQ-014 FSM states: IDLE, MARK, SPACE. IDLE->MARK on key_s rise; MARK->SPACE on key_s fall; SPACE->MARK on key_s rise; SPACE->IDLE after the char or word gap is fully resolved.
REQ-015 On MARK->SPACE: duration < 2*unit_ms appends dit (0), otherwise dah (1) to a 6-element shift register with a 3-bit element count.
REQ-016 In MARK, duration reaching 8*unit_ms (stuck key) shall flag the pending character as error; the FSM remains in MARK until key_s falls.
REQ-017 A 7th element shall flag the pending character as error; further elements are discarded.
REQ-018 In SPACE, duration reaching 2*unit_ms with count > 0 shall emit the character (LUT result, or 63 if flagged or the pattern is unassigned) and clear the element buffer and flag.
REQ-019 In SPACE, duration reaching 5*unit_ms after an emitted character shall emit code 36 once, then go to IDLE.
REQ-020 char_valid_o shall assert exactly one cycle after the threshold tick; char_o, seven_segment_o[6:0] hold until the next emission.
REQ-021 A key_s rise on the same cycle as a gap threshold tick shall take priority: no emission; the gap is treated as intra-character.
REQ-022 Mark or space shorter than one tick still counts (dit / intra-character gap).

Reset
REQ-023 While rstn_i low: FSM = IDLE, counters, prescaler, synchronizer, element buffer = 0, char_o = 36, char_valid_o = error_o = 0, seven_segment_o = 8'h00.
REQ-024 Reset mid-character shall discard the pending elements with no emission after release.

Configuration
REQ-025 Macro MORSE_DEC_WORDGAP_EN: defined -> REQ-019 word-space emission active; undefined -> no code 36 is ever emitted, SPACE->IDLE occurs right after the character emission, and the 5-unit comparator is not built.

Structure
REQ-026 Package morse_dec_pkg shall hold the unit_ms table, the code constants (SPACE = 36, ERR = 63), the FSM state enum, and the code-to-segment table.
REQ-027 Sub-module morse_lut (combinational): element pattern + count -> 6-bit code, 63 for unassigned patterns.

Verification (TICK_DIV = 1, wpm_sel_i = 15 -> unit 34 ticks)
REQ-028 Mark 34, space 34, mark 102, space 200 -> char_o = 0 ('A') at the 68th space tick + 1 cycle, then 36 at tick 170 + 1 (WORDGAP_EN defined).
REQ-029 Five 102-tick marks separated by 34-tick spaces, then space 80 -> char_o = 26 ('0'), seven_segment_o[6:0] = 0x3F.
REQ-030 Mark held 300 ticks, then space 80 -> char_o = 63, error_o pulses once.
REQ-031 Seven dits (34/34), then space 80 -> char_o = 63, error_o pulses.
REQ-032 Key rises exactly on space tick 68 -> no char_valid_o; the elements continue the same character.
REQ-033 rstn_i asserted after two dits, released, space 200 -> no char_valid_o; char_o = 36, seven_segment_o = 0x00.
